vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery: detects sync edges, tracks raster position,
// verifies line/frame geometry, declares lock and re-emits active pixels with (x, y).
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_LEN   = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_LEN   = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_de,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_err,
  output logic [10:0] o_line_len,
  output logic [10:0] o_frame_lines
);

  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0]   H_TOT     = 11'(H_TOTAL);
  localparam logic [10:0]   H_MAX     = 11'(2 * H_TOTAL);
  localparam logic [10:0]   V_TOT     = 11'(V_TOTAL);
  localparam logic [10:0]   V_MAX     = 11'(2 * V_TOTAL);
  localparam logic [10:0]   HA_LO     = 11'(H_ACT_START);
  localparam logic [10:0]   HA_HI     = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [10:0]   VA_LO     = 11'(V_ACT_START);
  localparam logic [10:0]   VA_HI     = 11'(V_ACT_START + V_ACT_LEN);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Stage-1 input registers and edge history
  logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [3:0]  red_q, green_q, blue_q;

  logic [10:0] h_cnt_q, v_cnt_q;
  state_t      state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic        first_q, first_d;

  // Output registers
  logic [9:0]  x_q, y_q;
  logic        de_q, locked_q, fs_q, err_q;
  logic [3:0]  ored_q, ogreen_q, oblue_q;
  logic [10:0] line_len_q, frame_lines_q;

  logic        hs_rise, vs_rise;
  logic [10:0] h_cur, v_cur;
  logic        line_bad, frame_bad, tmo, viol;
  logic        err_d, de_d;
  logic [9:0]  x_d, y_d;

  assign hs_rise = hs_q & ~hs_prev_q;
  assign vs_rise = vs_q & ~vs_prev_q;

  // h_cur/v_cur are the raster position of the pixel currently held in stage 1
  always_comb begin
    h_cur = '0;
    if (!hs_rise) begin
      h_cur = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 11'd1;
    end
    v_cur = v_cnt_q;
    if (vs_rise) begin
      v_cur = '0;
    end else if (hs_rise) begin
      v_cur = (v_cnt_q == V_MAX) ? V_MAX : v_cnt_q + 11'd1;
    end
  end

  always_comb begin
    line_bad  = hs_rise && !first_q && ((h_cnt_q + 11'd1) != H_TOT);
    frame_bad = vs_rise && ((v_cnt_q + 11'd1) != V_TOT);
    tmo       = ((h_cur == H_MAX) && (h_cnt_q != H_MAX)) ||
                ((v_cur == V_MAX) && (v_cnt_q != V_MAX));
    viol      = line_bad | frame_bad | tmo;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    first_d = first_q;
    err_d   = 1'b0;
    if (hs_rise) begin
      first_d = 1'b0;
    end
    unique case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = VERIFY;
          good_d  = '0;
          first_d = 1'b1;
        end
      end
      VERIFY: begin
        if (viol) begin
          state_d = SEARCH;
        end else if (vs_rise) begin
          if ((good_q + GW'(1)) == GOOD_LOCK) begin
            state_d = LOCKED;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    de_d = (state_q == LOCKED) &&
           (h_cur >= HA_LO) && (h_cur < HA_HI) &&
           (v_cur >= VA_LO) && (v_cur < VA_HI);
    x_d  = de_d ? 10'(h_cur - HA_LO) : 10'd0;
    y_d  = de_d ? 10'(v_cur - VA_LO) : 10'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      first_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      ored_q        <= '0;
      ogreen_q      <= '0;
      oblue_q       <= '0;
      locked_q      <= 1'b0;
      fs_q          <= 1'b0;
      err_q         <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      hs_q      <= i_hsync;
      vs_q      <= i_vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      red_q     <= i_red;
      green_q   <= i_green;
      blue_q    <= i_blue;
      h_cnt_q   <= h_cur;
      v_cnt_q   <= v_cur;
      state_q   <= state_d;
      good_q    <= good_d;
      first_q   <= first_d;
      x_q       <= x_d;
      y_q       <= y_d;
      de_q      <= de_d;
      ored_q    <= de_d ? red_q   : 4'd0;
      ogreen_q  <= de_d ? green_q : 4'd0;
      oblue_q   <= de_d ? blue_q  : 4'd0;
      locked_q  <= (state_d == LOCKED);
      fs_q      <= vs_rise;
      err_q     <= err_d;
      if (hs_rise) begin
        line_len_q <= h_cnt_q + 11'd1;
      end
      if (vs_rise) begin
        frame_lines_q <= v_cnt_q + 11'd1;
      end
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_de          = de_q;
  assign o_red         = ored_q;
  assign o_green       = ogreen_q;
  assign o_blue        = oblue_q;
  assign o_locked      = locked_q;
  assign o_frame_start = fs_q;
  assign o_err         = err_q;
  assign o_line_len    = line_len_q;
  assign o_frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a reduced 20x12 raster so whole
// frames run quickly; expectations are pushed as stimulus is driven.
module tb_vga_sync_decoder;

  localparam int HT = 20;
  localparam int VT = 12;
  localparam int HS = 5;
  localparam int HL = 10;
  localparam int VS = 3;
  localparam int VL = 6;
  localparam int LF = 2;

  logic        clk;
  logic        reset_n;
  logic        i_hsync, i_vsync;
  logic [3:0]  i_red, i_green, i_blue;
  logic [9:0]  o_x, o_y;
  logic        o_de;
  logic [3:0]  o_red, o_green, o_blue;
  logic        o_locked, o_frame_start, o_err;
  logic [10:0] o_line_len, o_frame_lines;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HS), .H_ACT_LEN(HL),
    .V_ACT_START(VS), .V_ACT_LEN(VL), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_x(o_x), .o_y(o_y), .o_de(o_de),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_locked(o_locked), .o_frame_start(o_frame_start), .o_err(o_err),
    .o_line_len(o_line_len), .o_frame_lines(o_frame_lines)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int x; int y; int r; int g; int b; } pix_t;
  typedef struct { int lines; int llen; int locked; } fs_t;

  pix_t pix_exp[$];
  fs_t  fs_exp[$];
  int   err_exp[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=output_present required=none_expected", name);
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, o_x, o_y, o_de, o_red, o_green, o_blue, o_locked,
            o_frame_start, o_err, o_line_len, o_frame_lines};
  endfunction

  // Monitor: one line per popped transaction
  initial begin
    pix_t p;
    fs_t  f;
    int   e;
    forever begin
      @(negedge clk);
      if (o_frame_start) begin
        if (fs_exp.size() == 0) unexpected("frame_start");
        else begin
          f = fs_exp.pop_front();
          $display("t=%0t frame_start lines=%0d len=%0d locked=%0d", $time, o_frame_lines, o_line_len, o_locked);
          if (f.lines >= 0) check("fs_frame_lines", 64'(o_frame_lines), 64'(f.lines));
          if (f.llen >= 0) check("fs_line_len", 64'(o_line_len), 64'(f.llen));
          check("fs_locked", 64'(o_locked), 64'(f.locked));
        end
      end
      if (o_err) begin
        if (err_exp.size() == 0) unexpected("err");
        else begin
          e = err_exp.pop_front();
          $display("t=%0t err len=%0d locked=%0d", $time, o_line_len, o_locked);
          if (e >= 0) check("err_line_len", 64'(o_line_len), 64'(e));
          check("err_locked", 64'(o_locked), 64'd0);
        end
      end
      if (o_de) begin
        if (pix_exp.size() == 0) unexpected("pixel");
        else begin
          p = pix_exp.pop_front();
          $display("t=%0t pixel x=%0d y=%0d rgb=%h%h%h", $time, o_x, o_y, o_red, o_green, o_blue);
          check("pix_x", 64'(o_x), 64'(p.x));
          check("pix_y", 64'(o_y), 64'(p.y));
          check("pix_rgb", 64'({o_red, o_green, o_blue}), 64'({p.r[3:0], p.g[3:0], p.b[3:0]}));
        end
      end else begin
        check("idle_zero", 64'({o_x, o_y, o_red, o_green, o_blue}), 64'd0);
      end
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic [3:0] r,
                       input logic [3:0] g, input logic [3:0] b);
    @(posedge clk);
    #1;
    i_hsync = hs;
    i_vsync = vs;
    i_red   = r;
    i_green = g;
    i_blue  = b;
  endtask

  task automatic reset_midframe();
    check("locked_before_reset", 64'(o_locked), 64'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async_outputs", all_outs(), 64'd0);
    $display("t=%0t reset asserted mid-frame", $time);
    i_hsync = 1'b0; i_vsync = 1'b0; i_red = '0; i_green = '0; i_blue = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One frame; short/stall/rst select a faulty line (-1 = none).
  // fs_* are the hand-derived values expected at this frame's o_frame_start.
  task automatic run_frame(input int n_lines, input int short_line, input int stall_line,
                           input int rst_line, input int pat, input int fs_lines,
                           input int fs_llen, input int fs_lk);
    int   lk;
    int   len;
    logic [3:0] r, g, b;
    pix_t p;
    fs_t  f;
    lk = fs_lk;
    for (int v = 0; v < n_lines; v++) begin
      if (v == rst_line) begin
        reset_midframe();
        return;
      end
      if (v == stall_line) begin
        if (lk != 0) err_exp.push_back(-1);
        repeat (3 * HT) drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        return;
      end
      len = (v == short_line) ? HT - 1 : HT;
      if (v == short_line && lk != 0) err_exp.push_back(HT - 1);
      for (int h = 0; h < len; h++) begin
        if (pat == 0) begin
          r = 4'(h); g = 4'(v); b = 4'(h + v);
        end else begin
          r = (h == HS && v == VS) ? 4'hF : 4'h0; g = 4'h0; b = 4'h0;
        end
        if (v == 0 && h == 0) begin
          f.lines = fs_lines; f.llen = fs_llen; f.locked = fs_lk;
          fs_exp.push_back(f);
        end
        if (lk != 0 && h >= HS && h < HS + HL && v >= VS && v < VS + VL) begin
          p.x = h - HS; p.y = v - VS; p.r = int'(r); p.g = int'(g); p.b = int'(b);
          pix_exp.push_back(p);
        end
        drive(h < 3, v < 2, r, g, b);
      end
      if (v == short_line) lk = 0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_hsync = 1'b0; i_vsync = 1'b0; i_red = '0; i_green = '0; i_blue = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;

    // Nominal lock: third frame start locks
    run_frame(VT, -1, -1, -1, 0, 1,  -1, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 1);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 1);
    // Single marked pixel at the first active position
    run_frame(VT, -1, -1, -1, 1, VT, HT, 1);
    // Short line while locked, then relock
    run_frame(VT, 4, -1, -1, 0, VT, HT, 1);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 1);
    // hsync stall while locked: timeout, then recovery
    run_frame(VT, -1, 4, -1, 0, VT, HT, 1);
    run_frame(VT, -1, -1, -1, 0, 4, 2 * HT + 1, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 1);
    // Reset mid-frame, lock returns at third vsync
    run_frame(VT, -1, -1, 6, 0, VT, HT, 1);
    run_frame(VT, -1, -1, -1, 0, 1,  -1, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 1);
    // Bad (short) frame during VERIFY: silent drop, lock three good frames later
    run_frame(VT, 4, -1, -1, 0, VT, HT, 1);
    run_frame(VT - 1, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT - 1, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 0);
    run_frame(VT, -1, -1, -1, 0, VT, HT, 1);
    // Syncs stop while locked: timeout error
    err_exp.push_back(-1);
    repeat (3 * HT) drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    repeat (5) @(posedge clk);
    #1;
    check("pix_queue_drained", 64'(pix_exp.size()), 64'd0);
    check("fs_queue_drained", 64'(fs_exp.size()), 64'd0);
    check("err_queue_drained", 64'(err_exp.size()), 64'd0);
    check("unlocked_at_end", 64'(o_locked), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
